// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache: 8 blocks x 4 bytes, 8-bit byte address.
// Hits are served combinationally in IDLE; misses run WRITEBACK/FETCH/ALLOCATE.
module dcache_ctrl (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, ALLOCATE} state_t;
  state_t state, nstate;

  logic [7:0][31:0] data_q;
  logic [7:0][2:0]  tag_q;
  logic [7:0]       valid_q, dirty_q;
  logic [31:0]      fill_q;

  logic [2:0] tag_in, idx;
  logic [1:0] off;
  logic       req, hit, wr_hit;

  assign tag_in = address[7:5];
  assign idx    = address[4:2];
  assign off    = address[1:0];
  assign req    = read | write;
  assign hit    = valid_q[idx] & (tag_q[idx] == tag_in);
  assign wr_hit = (state == IDLE) & write & hit;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:      if (req && !hit) nstate = dirty_q[idx] ? WRITEBACK : FETCH;
      WRITEBACK: if (!mem_busywait) nstate = FETCH;
      FETCH:     if (!mem_busywait) nstate = ALLOCATE;
      ALLOCATE:  nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  always_comb begin
    readdata      = 8'h00;
    busywait      = req & ~((state == IDLE) & hit);
    mem_address   = 6'h00;
    mem_writedata = 32'h0;
    if (read) readdata = data_q[idx][{off, 3'b000} +: 8];
    case (state)
      WRITEBACK: begin
        mem_address   = {tag_q[idx], idx};
        mem_writedata = data_q[idx];
      end
      FETCH:   mem_address = address[7:2];
      default: ;
    endcase
  end

  // Control state; memory strobes are registered off nstate so they stay Moore.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state     <= nstate;
      mem_read  <= (nstate == FETCH);
      mem_write <= (nstate == WRITEBACK);
      if (state == ALLOCATE) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (wr_hit) dirty_q[idx] <= 1'b1;
    end
  end

  // Data and tag arrays need no reset: valid=0 hides stale contents.
  always_ff @(posedge CLOCK) begin
    if (state == FETCH && !mem_busywait) fill_q <= mem_readdata;
    if (state == ALLOCATE) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= tag_in;
    end
    if (wr_hit) data_q[idx][{off, 3'b000} +: 8] <= writedata;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency block memory model.
module tb_dcache_ctrl;
  localparam int LAT = 3;  // memory request occupies LAT+1 cycles

  logic        CLOCK = 1'b0, RESET = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [7:0]  address = 8'h00, writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  int tests = 0, fails = 0;

  dcache_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLOCK = ~CLOCK;

  // memory model
  logic [31:0] mem [64];
  int cnt = 0;
  assign mem_busywait = (mem_read | mem_write) && (cnt < LAT);
  assign mem_readdata = mem[mem_address];
  always @(posedge CLOCK) begin
    if (mem_read | mem_write) begin
      if (mem_busywait) cnt <= cnt + 1;
      else begin
        cnt <= 0;
        if (mem_write) mem[mem_address] <= mem_writedata;
      end
    end else cnt <= 0;
  end

  // traffic monitor
  int rd_cyc = 0, wr_cyc = 0, both_hi = 0;
  logic [5:0]  rd_addr = 6'h00, wr_addr = 6'h00;
  logic [31:0] wr_data = 32'h0;
  always @(negedge CLOCK) begin
    if (mem_read)  begin rd_cyc++; rd_addr = mem_address; end
    if (mem_write) begin wr_cyc++; wr_addr = mem_address; wr_data = mem_writedata; end
    if (mem_read && mem_write) both_hi++;
  end

  task automatic clr_mon();
    rd_cyc = 0; wr_cyc = 0; rd_addr = 6'h00; wr_addr = 6'h00; wr_data = 32'h0;
  endtask

  // One CPU access held until busywait drops; stall = cycles with busywait high.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output int stall, output logic [7:0] rdat);
    stall = 0;
    @(negedge CLOCK);
    read = rd; write = wr; address = a; writedata = wd;
    #1;
    while (busywait === 1'b1 && stall < 50) begin
      stall++;
      @(negedge CLOCK); #1;
    end
    rdat = readdata;
    @(negedge CLOCK);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK); RESET = 1'b0; #1;
    tests++; if (busywait !== 1'b0) begin fails++; $display("FAIL reset_busywait got %b want 0", busywait); end
    tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL reset_strobes got r=%b w=%b want 0/0", mem_read, mem_write); end
    tests++; if (readdata !== 8'h00) begin fails++; $display("FAIL reset_readdata got %h want 00", readdata); end
    tests++; if (mem_address !== 6'h00) begin fails++; $display("FAIL reset_mem_address got %h want 00", mem_address); end
  endtask

  task automatic test_clean_miss();
    int st; logic [7:0] d;
    clr_mon();
    access(1'b1, 1'b0, 8'h14, 8'h00, st, d);
    tests++; if (st !== 6) begin fails++; $display("FAIL miss_stall got %0d want 6", st); end
    tests++; if (d !== 8'hAA) begin fails++; $display("FAIL miss_readdata got %h want aa", d); end
    tests++; if (rd_addr !== 6'h05 || rd_cyc !== LAT + 1) begin fails++; $display("FAIL miss_fetch got addr=%h cyc=%0d want 05/%0d", rd_addr, rd_cyc, LAT + 1); end
    tests++; if (wr_cyc !== 0) begin fails++; $display("FAIL miss_no_wb got %0d write cycles want 0", wr_cyc); end
  endtask

  task automatic test_read_hits();
    logic [7:0] a [3];
    logic [7:0] e [3];
    a[0] = 8'h14; a[1] = 8'h15; a[2] = 8'h17;
    e[0] = 8'hAA; e[1] = 8'hBB; e[2] = 8'hDD;
    clr_mon();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK); read = 1'b1; address = a[i]; #1;
      tests++; if (busywait !== 1'b0 || readdata !== e[i]) begin fails++; $display("FAIL hit_%0d got bw=%b d=%h want 0/%h", i, busywait, readdata, e[i]); end
    end
    @(negedge CLOCK); read = 1'b0;
    tests++; if (rd_cyc !== 0 || wr_cyc !== 0) begin fails++; $display("FAIL hit_traffic got r=%0d w=%0d want 0/0", rd_cyc, wr_cyc); end
  endtask

  task automatic test_write_hit();
    int st; logic [7:0] d;
    clr_mon();
    access(1'b0, 1'b1, 8'h16, 8'h5A, st, d);
    tests++; if (st !== 0) begin fails++; $display("FAIL wrhit_stall got %0d want 0", st); end
    access(1'b1, 1'b0, 8'h16, 8'h00, st, d);
    tests++; if (st !== 0 || d !== 8'h5A) begin fails++; $display("FAIL wrhit_readback got st=%0d d=%h want 0/5a", st, d); end
    tests++; if (rd_cyc !== 0 || wr_cyc !== 0) begin fails++; $display("FAIL wrhit_traffic got r=%0d w=%0d want 0/0", rd_cyc, wr_cyc); end
  endtask

  task automatic test_dirty_conflict();
    int st; logic [7:0] d;
    clr_mon();
    access(1'b0, 1'b1, 8'hB4, 8'hC3, st, d);
    tests++; if (st !== 2 * (LAT + 1) + 2) begin fails++; $display("FAIL dirty_stall got %0d want %0d", st, 2 * (LAT + 1) + 2); end
    tests++; if (wr_addr !== 6'h05 || wr_data !== 32'hDD5ABBAA || wr_cyc !== LAT + 1) begin fails++; $display("FAIL dirty_wb got a=%h d=%h c=%0d want 05/dd5abbaa/%0d", wr_addr, wr_data, wr_cyc, LAT + 1); end
    tests++; if (rd_addr !== 6'h2D || rd_cyc !== LAT + 1) begin fails++; $display("FAIL dirty_fetch got a=%h c=%0d want 2d/%0d", rd_addr, rd_cyc, LAT + 1); end
    tests++; if (mem[5] !== 32'hDD5ABBAA) begin fails++; $display("FAIL dirty_memory got %h want dd5abbaa", mem[5]); end
    access(1'b1, 1'b0, 8'hB4, 8'h00, st, d);
    tests++; if (st !== 0 || d !== 8'hC3) begin fails++; $display("FAIL dirty_store got st=%0d d=%h want 0/c3", st, d); end
    access(1'b1, 1'b0, 8'hB5, 8'h00, st, d);
    tests++; if (st !== 0 || d !== 8'h22) begin fails++; $display("FAIL dirty_fill got st=%0d d=%h want 0/22", st, d); end
  endtask

  task automatic test_reset_fetch();
    int st; logic [7:0] d;
    @(negedge CLOCK); read = 1'b1; address = 8'h08;
    @(negedge CLOCK); #1;
    tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rstf_in_fetch got mem_read=%b want 1", mem_read); end
    @(negedge CLOCK); RESET = 1'b1; read = 1'b0;
    @(negedge CLOCK); RESET = 1'b0; #1;
    tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 6'h00) begin fails++; $display("FAIL rstf_abort got r=%b w=%b a=%h want 0/0/00", mem_read, mem_write, mem_address); end
    clr_mon();
    access(1'b1, 1'b0, 8'h14, 8'h00, st, d);
    tests++; if (st !== LAT + 3 || d !== 8'hAA) begin fails++; $display("FAIL rstf_remiss got st=%0d d=%h want %0d/aa", st, d, LAT + 3); end
    tests++; if (wr_cyc !== 0 || rd_cyc !== LAT + 1) begin fails++; $display("FAIL rstf_clean got w=%0d r=%0d want 0/%0d", wr_cyc, rd_cyc, LAT + 1); end
  endtask

  task automatic test_read_write_both();
    int st; logic [7:0] d;
    clr_mon();
    access(1'b1, 1'b1, 8'h00, 8'h77, st, d);
    tests++; if (st !== LAT + 3) begin fails++; $display("FAIL rw_stall got %0d want %0d", st, LAT + 3); end
    tests++; if (d !== 8'hF0) begin fails++; $display("FAIL rw_readdata got %h want f0", d); end
    access(1'b1, 1'b0, 8'h00, 8'h00, st, d);
    tests++; if (st !== 0 || d !== 8'h77) begin fails++; $display("FAIL rw_stored got st=%0d d=%h want 0/77", st, d); end
    access(1'b1, 1'b0, 8'h01, 8'h00, st, d);
    tests++; if (st !== 0 || d !== 8'h01) begin fails++; $display("FAIL rw_neighbour got st=%0d d=%h want 0/01", st, d); end
    tests++; if (wr_cyc !== 0) begin fails++; $display("FAIL rw_no_wb got %0d want 0", wr_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {2'b00, i[5:0], 24'h0};
    mem[6'h05] = 32'hDDCCBBAA;
    mem[6'h2D] = 32'h44332211;
    mem[6'h00] = 32'h030201F0;
    test_reset();
    test_clean_miss();
    test_read_hits();
    test_write_hit();
    test_dirty_conflict();
    test_reset_fetch();
    test_read_write_both();
    tests++; if (both_hi !== 0) begin fails++; $display("FAIL strobes_exclusive got %0d overlap cycles want 0", both_hi); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
